// File: rtl/adaptive_fir_p_if.sv
// Sample, handshake and host coefficient-port signals of the adaptive FIR.
// The master drives stimulus and coefficients; the slave is the filter.
interface adaptive_fir_p_if #(
  parameter int DW = 32,
  parameter int CW = 32,
  parameter int AW = 7
);
  logic [DW-1:0] feedforward_in;
  logic [DW-1:0] mu_err;
  logic          adapt_en;
  logic          go;
  logic          hist_clr;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_wdata;
  logic [CW-1:0] coef_rdata;
  logic          busy;
  logic [DW-1:0] out_sample;
  logic          out_valid;
  logic          done;

  modport master (
    output feedforward_in, mu_err, adapt_en, go, hist_clr,
           coef_we, coef_addr, coef_wdata,
    input  coef_rdata, busy, out_sample, out_valid, done
  );

  modport slave (
    input  feedforward_in, mu_err, adapt_en, go, hist_clr,
           coef_we, coef_addr, coef_wdata,
    output coef_rdata, busy, out_sample, out_valid, done
  );
endinterface

// File: rtl/adaptive_fir_p.sv
// Sequential (one tap per cycle) LMS-style adaptive FIR producing an a-priori output.
// Each go computes one output sample over TAPS+3 cycles, optionally updating weights.
module adaptive_fir_p #(
  parameter int DW   = 32,
  parameter int CW   = 32,
  parameter int TAPS = 128,
  parameter int FRAC = 15,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic            clk,
  input  logic            rst_n,
  adaptive_fir_p_if.slave bus
);
  localparam int MW   = (DW > CW) ? DW : CW;
  localparam int PW   = 2 * MW;
  localparam int SW   = PW + 1;
  localparam int ACCW = PW + $clog2(TAPS) + 1;
  localparam int IW   = $clog2(TAPS);

  localparam logic signed [SW-1:0]   W_MAX = (SW'(1) <<< (CW - 1)) - SW'(1);
  localparam logic signed [SW-1:0]   W_MIN = -(SW'(1) <<< (CW - 1));
  localparam logic signed [ACCW-1:0] O_MAX = (ACCW'(1) <<< (DW - 1)) - ACCW'(1);
  localparam logic signed [ACCW-1:0] O_MIN = -(ACCW'(1) <<< (DW - 1));

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic                   busy_q;
  logic signed [CW-1:0]   w [TAPS];
  logic signed [DW-1:0]   x [TAPS];
  logic signed [DW-1:0]   mu_lat;
  logic                   adapt_lat;
  logic signed [PW-1:0]   p;
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0]   out_q;
  logic                   out_valid_q;
  logic                   done_q;
  logic [CW-1:0]          coef_rdata_q;

  logic                   addr_ok;
  logic [IW-1:0]          addr_idx;
  logic signed [CW-1:0]   w_k;
  logic signed [DW-1:0]   x_k;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   mu_x;
  logic signed [SW-1:0]   w_sum;
  logic signed [CW-1:0]   w_new;
  logic signed [ACCW-1:0] acc_sh;
  logic signed [DW-1:0]   out_sat;

  // Addresses beyond the last tap (only possible when TAPS is not a power of two) are dropped.
  assign addr_ok  = (32'(bus.coef_addr) < 32'(TAPS));
  assign addr_idx = IW'(bus.coef_addr);
  assign w_k      = w[idx];
  assign x_k      = x[idx];

  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    prod  = PW'(w_k) * PW'(x_k);
    mu_x  = (PW'(mu_lat) * PW'(x_k)) >>> FRAC;
    w_sum = SW'(w_k) + SW'(mu_x);
    if (w_sum > W_MAX)      w_new = W_MAX[CW-1:0];
    else if (w_sum < W_MIN) w_new = W_MIN[CW-1:0];
    else                    w_new = w_sum[CW-1:0];

    acc_sh = acc >>> FRAC;
    if (acc_sh > O_MAX)      out_sat = O_MAX[DW-1:0];
    else if (acc_sh < O_MIN) out_sat = O_MIN[DW-1:0];
    else                     out_sat = acc_sh[DW-1:0];
  end

  // Coefficient and history storage. Host writes land before a same-cycle go uses them.
  // NOTE: these arrays are plain flops rather than RAM, so they take the async reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        w[k] <= '0;
        x[k] <= '0;
      end
    end else if (state == IDLE) begin
      if (bus.coef_we && addr_ok) w[addr_idx] <= bus.coef_wdata;
      if (bus.hist_clr) begin
        for (int k = 0; k < TAPS; k++) x[k] <= '0;
        if (bus.go) x[0] <= bus.feedforward_in;
      end else if (bus.go) begin
        for (int k = TAPS - 1; k > 0; k--) x[k] <= x[k-1];
        x[0] <= bus.feedforward_in;
      end
    end else if (state == RUN && adapt_lat) begin
      w[idx] <= w_new;
    end
  end

  // Control FSM with the product/accumulate pipeline and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      busy_q       <= 1'b0;
      mu_lat       <= '0;
      adapt_lat    <= 1'b0;
      p            <= '0;
      acc          <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      coef_rdata_q <= '0;
    end else begin
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      coef_rdata_q <= addr_ok ? w[addr_idx] : '0;
      case (state)
        IDLE: if (bus.go) begin
          mu_lat    <= bus.mu_err;
          adapt_lat <= bus.adapt_en;
          acc       <= '0;
          idx       <= '0;
          busy_q    <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          // p lags by one tap, so the first RUN cycle has nothing to accumulate yet.
          p <= prod;
          if (idx != '0) acc <= acc + ACCW'(p);
          if (idx == IW'(TAPS - 1)) state <= FLUSH;
          else                      idx   <= idx + IW'(1);
        end
        FLUSH: begin
          acc   <= acc + ACCW'(p);
          state <= OUT;
        end
        OUT: begin
          out_q       <= out_sat;
          out_valid_q <= 1'b1;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.out_sample = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.done       = done_q;
  assign bus.coef_rdata = coef_rdata_q;
endmodule
